read_master_csr: RTL and testbench

READ_MASTER_CSR -- requirements
Module: read_master_csr

---
 rtl/read_master_csr_pkg.sv | 36 +++
 rtl/read_master_csr_scfifo.sv | 51 +++++
 rtl/read_master_csr.sv | 148 ++++++++++++++
 tb/tb_read_master_csr.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/read_master_csr_pkg.sv
// Shared CSR map and status packing for the DMA read/write masters.
package read_master_csr_pkg;

  localparam int unsigned CSR_ADDR_W = 4;
  localparam int unsigned CSR_DATA_W = 32;

  localparam logic [CSR_ADDR_W-1:0] CSR_CONTROL        = 4'd0;
  localparam logic [CSR_ADDR_W-1:0] CSR_STATUS         = 4'd1;
  localparam logic [CSR_ADDR_W-1:0] CSR_LENGTH         = 4'd2;
  localparam logic [CSR_ADDR_W-1:0] CSR_READ_ADDR_BASE = 4'd3;
  localparam logic [CSR_ADDR_W-1:0] CSR_USER_DATA      = 4'd4;
  localparam logic [CSR_ADDR_W-1:0] CSR_POP            = 4'd5;

  localparam int unsigned CTRL_GO_BIT    = 0;
  localparam int unsigned CTRL_FIXED_BIT = 1;
  localparam int unsigned POP_BIT        = 0;

  typedef struct packed {
    logic [CSR_DATA_W-4:0] reserved;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  done;
  } status_t;

  function automatic logic [CSR_DATA_W-1:0] pack_status(input logic full,
                                                        input logic empty,
                                                        input logic done);
    status_t s;
    s.reserved   = '0;
    s.fifo_full  = full;
    s.fifo_empty = empty;
    s.done       = done;
    return CSR_DATA_W'(s);
  endfunction

endpackage

// File: rtl/read_master_csr_scfifo.sv
// Single-clock show-ahead FIFO; no overflow/underflow protection, callers gate requests.
module read_master_csr_scfifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  wrreq,
  input  logic [WIDTH-1:0]      data,
  input  logic                  rdreq,
  output logic [WIDTH-1:0]      q,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2-1:0] usedw
);

  localparam int unsigned CW = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;

  always_ff @(posedge clk) begin
    if (wrreq) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wrreq) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (rdreq) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({wrreq, rdreq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Show-ahead: head word is visible without a read request.
  assign q     = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign usedw = count[DEPTH_LOG2-1:0];

endmodule

// File: rtl/read_master_csr.sv
// CSR-programmed read master: streams LENGTH bytes from a base address into a
// receive FIFO that software drains through the USER_DATA/POP registers.
module read_master_csr
  import read_master_csr_pkg::*;
#(
  parameter int unsigned DATAWIDTH       = 32,
  parameter int unsigned BYTEENABLEWIDTH = 4,
  parameter int unsigned ADDRESSWIDTH    = 32,
  parameter int unsigned FIFODEPTH       = 32,
  parameter int unsigned FIFODEPTH_LOG2  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CSR_ADDR_W-1:0]      avs_csr_address,
  input  logic                       avs_csr_write,
  input  logic [CSR_DATA_W-1:0]      avs_csr_writedata,
  input  logic                       avs_csr_read,
  output logic [CSR_DATA_W-1:0]      avs_csr_readdata,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_read,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  input  logic [DATAWIDTH-1:0]       master_readdata,
  input  logic                       master_readdatavalid,
  input  logic                       master_waitrequest
);

  localparam int unsigned OW = FIFODEPTH_LOG2 + 1;
  localparam int unsigned SW = OW + 1;

  logic [CSR_DATA_W-1:0]     length_reg;
  logic [CSR_DATA_W-1:0]     base_reg;
  logic [CSR_DATA_W-1:0]     status_reg;
  logic                      go;
  logic                      fixed_wr;
  logic                      fixed_d1;
  logic                      pop_strobe;
  logic [ADDRESSWIDTH-1:0]   address;
  logic [ADDRESSWIDTH-1:0]   remaining;
  logic [ADDRESSWIDTH-1:0]   length_aw;
  logic [OW-1:0]             outstanding;
  logic [OW-1:0]             fifo_used;
  logic                      accept;
  logic                      done;
  logic                      fifo_rdreq;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic [FIFODEPTH_LOG2-1:0] fifo_usedw;
  logic [DATAWIDTH-1:0]      fifo_q;
  logic                      unused_csr_read;

  assign unused_csr_read = avs_csr_read;

  wire csr_wr_control = avs_csr_write && (avs_csr_address == CSR_CONTROL);
  wire csr_wr_pop     = avs_csr_write && (avs_csr_address == CSR_POP);

  // CSR register writes; go and pop are registered single-cycle strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      length_reg <= '0;
      base_reg   <= '0;
      go         <= 1'b0;
      fixed_wr   <= 1'b0;
      pop_strobe <= 1'b0;
    end else begin
      go         <= csr_wr_control && avs_csr_writedata[CTRL_GO_BIT];
      pop_strobe <= csr_wr_pop && avs_csr_writedata[POP_BIT];
      if (csr_wr_control) fixed_wr <= avs_csr_writedata[CTRL_FIXED_BIT];
      if (avs_csr_write && (avs_csr_address == CSR_LENGTH))
        length_reg <= avs_csr_writedata;
      if (avs_csr_write && (avs_csr_address == CSR_READ_ADDR_BASE))
        base_reg <= avs_csr_writedata;
    end
  end

  assign length_aw = ADDRESSWIDTH'(length_reg);
  assign fifo_used = fifo_full ? OW'(FIFODEPTH) : OW'(fifo_usedw);

  // Reserve FIFO space for every read in flight so responses can never overflow it.
  assign master_read = (remaining != '0) &&
                       ((SW'(fifo_used) + SW'(outstanding)) < SW'(FIFODEPTH));
  assign accept            = master_read && !master_waitrequest;
  assign master_address    = address;
  assign master_byteenable = '1;
  assign done              = (remaining == '0) && (outstanding == '0);

  // Address/length walker; a go reload wins over a same-cycle acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address   <= '0;
      remaining <= '0;
      fixed_d1  <= 1'b0;
    end else if (go) begin
      address   <= ADDRESSWIDTH'(base_reg);
      remaining <= {length_aw[ADDRESSWIDTH-1:2], 2'b00};
      fixed_d1  <= fixed_wr;
    end else if (accept) begin
      remaining <= remaining - ADDRESSWIDTH'(BYTEENABLEWIDTH);
      if (!fixed_d1) address <= address + ADDRESSWIDTH'(BYTEENABLEWIDTH);
    end
  end

  // Reads in flight; saturates at zero for stale responses arriving after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, master_readdatavalid})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) status_reg <= '0;
    else       status_reg <= pack_status(fifo_full, fifo_empty, done);
  end

  always_comb begin
    avs_csr_readdata = status_reg;
    case (avs_csr_address)
      CSR_LENGTH:         avs_csr_readdata = length_reg;
      CSR_READ_ADDR_BASE: avs_csr_readdata = base_reg;
      CSR_USER_DATA:      avs_csr_readdata = CSR_DATA_W'(fifo_q);
      default:            avs_csr_readdata = status_reg;
    endcase
  end

  assign fifo_rdreq = pop_strobe && !fifo_empty;

  read_master_csr_scfifo #(
    .WIDTH      (DATAWIDTH),
    .DEPTH      (FIFODEPTH),
    .DEPTH_LOG2 (FIFODEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .aclr  (reset),
    .wrreq (master_readdatavalid),
    .data  (master_readdata),
    .rdreq (fifo_rdreq),
    .q     (fifo_q),
    .empty (fifo_empty),
    .full  (fifo_full),
    .usedw (fifo_usedw)
  );

endmodule

// File: tb/tb_read_master_csr.sv
// Randomized bench: Avalon slave responder plus queue-based model of the read stream and FIFO.
module tb_read_master_csr;
  import read_master_csr_pkg::*;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  avs_csr_address = '0;
  logic        avs_csr_write = 1'b0;
  logic [31:0] avs_csr_writedata = '0;
  logic        avs_csr_read = 1'b0;
  logic [31:0] avs_csr_readdata;
  logic [31:0] master_address;
  logic        master_read;
  logic [3:0]  master_byteenable;
  logic [31:0] master_readdata = '0;
  logic        master_readdatavalid = 1'b0;
  logic        master_waitrequest = 1'b0;

  read_master_csr dut (
    .clk                  (clk),
    .reset                (reset),
    .avs_csr_address      (avs_csr_address),
    .avs_csr_write        (avs_csr_write),
    .avs_csr_writedata    (avs_csr_writedata),
    .avs_csr_read         (avs_csr_read),
    .avs_csr_readdata     (avs_csr_readdata),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_byteenable    (master_byteenable),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_waitrequest   (master_waitrequest)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accepted = 0;
  int stall    = 0;
  int cur_wait = 0;
  int cur_lat  = 1;

  logic [31:0] exp_addr [$];
  logic [31:0] exp_fifo [$];
  logic [31:0] exp_csr  [$];
  int          pend_due [$];
  logic [31:0] pend_dat [$];

  function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endfunction

  function automatic logic [31:0] model_status();
    logic full, empty, done;
    full  = exp_fifo.size() >= DEPTH;
    empty = exp_fifo.size() == 0;
    done  = (exp_addr.size() == 0) && (pend_due.size() == 0);
    return {29'd0, full, empty, done};
  endfunction

  // Slave responder and master-channel monitor.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      pend_due.delete();
      pend_dat.delete();
      master_waitrequest   = 1'b0;
      master_readdatavalid = 1'b0;
      stall = 0;
    end else begin
      if (master_read && (exp_fifo.size() + pend_due.size() >= DEPTH))
        check("no_overflow_read", master_read, 0);
      check("byteenable", master_byteenable, 4'hF);
      if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
        master_readdatavalid = 1'b1;
        master_readdata = pend_dat.pop_front();
        void'(pend_due.pop_front());
        exp_fifo.push_back(master_readdata);
      end else begin
        master_readdatavalid = 1'b0;
        master_readdata = $urandom;
      end
      if (master_read && stall < cur_wait) begin
        master_waitrequest = 1'b1;
        stall++;
        if (exp_addr.size() != 0) check("stall_addr_hold", master_address, exp_addr[0]);
      end else begin
        master_waitrequest = 1'b0;
      end
      if (master_read && !master_waitrequest) begin
        stall = 0;
        accepted++;
        check("read_expected", 64'(exp_addr.size() != 0), 1);
        if (exp_addr.size() != 0) check("read_addr", master_address, exp_addr.pop_front());
        pend_due.push_back(cyc + cur_lat);
        pend_dat.push_back($urandom);
      end
    end
  end

  // CSR read monitor.
  always @(posedge clk) begin
    #1;
    if (!reset && avs_csr_read) begin
      if (avs_csr_address == CSR_USER_DATA) begin
        check("fifo_has_data", 64'(exp_fifo.size() != 0), 1);
        if (exp_fifo.size() != 0) check("user_data", avs_csr_readdata, exp_fifo.pop_front());
      end else begin
        check("csr_expected", 64'(exp_csr.size() != 0), 1);
        if (exp_csr.size() != 0) check("csr_read", avs_csr_readdata, exp_csr.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    avs_csr_address = a; avs_csr_writedata = d; avs_csr_write = 1'b1;
    tick();
    avs_csr_write = 1'b0;
  endtask

  task automatic csr_read(input logic [3:0] a, input logic [31:0] e);
    exp_csr.push_back(e);
    avs_csr_address = a; avs_csr_read = 1'b1;
    tick();
    avs_csr_read = 1'b0;
  endtask

  task automatic read_status();
    tick(); tick();
    csr_read(CSR_STATUS, model_status());
  endtask

  task automatic read_word();
    int n = 0;
    while (exp_fifo.size() == 0 && n < 200) begin tick(); n++; end
    check("word_arrives", 64'(exp_fifo.size() != 0), 1);
    if (exp_fifo.size() != 0) begin
      avs_csr_address = CSR_USER_DATA; avs_csr_read = 1'b1;
      tick();
      avs_csr_read = 1'b0;
      csr_write(CSR_POP, 32'h1);
      tick();
    end
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_addr.size() != 0 || pend_due.size() != 0) && n < 3000) begin tick(); n++; end
    check("transfer_completes", 64'(exp_addr.size() == 0 && pend_due.size() == 0), 1);
    tick(); tick();
  endtask

  task automatic run_xfer(input logic [31:0] base, input logic [31:0] len, input bit fixed,
                          input int wt, input int lat);
    cur_wait = wt; cur_lat = lat;
    for (int i = 0; i < int'(len / 4); i++)
      exp_addr.push_back(fixed ? base : base + 32'(4 * i));
    csr_write(CSR_LENGTH, len);
    csr_write(CSR_READ_ADDR_BASE, base);
    csr_write(CSR_CONTROL, {30'd0, fixed, 1'b1});
    csr_read(CSR_LENGTH, len);
    csr_read(CSR_READ_ADDR_BASE, base);
    wait_quiet();
    read_status();
    while (exp_fifo.size() != 0) read_word();
    read_status();
  endtask

  initial begin
    int acc0, n;
    #2;
    avs_csr_address = CSR_STATUS;
    #1;
    check("reset_master_read", master_read, 0);
    check("reset_master_address", master_address, 0);
    check("reset_status_cleared", avs_csr_readdata, 0);
    tick(); tick();
    reset = 1'b0;
    read_status();

    // Sequential, fixed-location and stalled transfers.
    run_xfer(32'h1000, 32'd16, 1'b0, 0, 1);
    run_xfer(32'h1000, 32'd16, 1'b1, 0, 1);
    run_xfer(32'h2000, 32'd16, 1'b0, 3, 5);

    // 64 words with no pops: reads throttle at 32 in flight/stored, then resume.
    cur_wait = 0; cur_lat = 1;
    for (int i = 0; i < 64; i++) exp_addr.push_back(32'h4000 + 32'(4 * i));
    acc0 = accepted;
    csr_write(CSR_LENGTH, 32'd256);
    csr_write(CSR_READ_ADDR_BASE, 32'h4000);
    csr_write(CSR_CONTROL, 32'h1);
    n = 0;
    while (!((accepted - acc0) >= DEPTH && pend_due.size() == 0) && n < 500) begin tick(); n++; end
    tick(); tick(); tick(); tick();
    check("throttle_master_read", master_read, 0);
    check("throttle_accept_count", 64'(accepted - acc0), DEPTH);
    read_status();
    for (int i = 0; i < 64; i++) read_word();
    wait_quiet();
    read_status();

    // Randomized transfers, including unaligned lengths that truncate to whole words.
    for (int k = 0; k < 8; k++)
      run_xfer({14'd0, 16'($urandom), 2'b00}, 32'($urandom_range(0, 72)),
               1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(1, 4));

    // Reset with reads outstanding.
    cur_wait = 0; cur_lat = 8;
    for (int i = 0; i < 16; i++) exp_addr.push_back(32'h8000 + 32'(4 * i));
    csr_write(CSR_LENGTH, 32'd64);
    csr_write(CSR_READ_ADDR_BASE, 32'h8000);
    csr_write(CSR_CONTROL, 32'h1);
    n = 0;
    while (pend_due.size() < 3 && n < 100) begin tick(); n++; end
    check("reads_in_flight", 64'(pend_due.size() >= 3), 1);
    reset = 1'b1;
    #1;
    check("midreset_master_read", master_read, 0);
    check("midreset_master_address", master_address, 0);
    tick(); tick();
    exp_addr.delete();
    exp_fifo.delete();
    reset = 1'b0;
    read_status();
    csr_read(CSR_LENGTH, 32'd0);

    run_xfer(32'h9000, 32'd24, 1'b0, 1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
